riscv_pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It collects stall requests from each stage and EX branch redirects, plus MEM-stage exceptions. From these it drives a per-register stall vector and flush vector to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences trap entry through a small FSM and keeps stall-watchdog and stall-cycle counters. In every pipeline register, stall takes priority over flush; this controller relies on that.

---
 rtl/riscv_pipe_ctrl_pkg.sv | 38 +++
 rtl/riscv_stall_wdog.sv | 52 +++++
 rtl/riscv_pipe_ctrl.sv | 117 +++++++++++
 tb/tb_riscv_pipe_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage bit positions,
// trap FSM states, exception cause codes and a stage-mask helper.
package riscv_pipe_ctrl_pkg;

  localparam int NSTG      = 5;
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;

  typedef logic [NSTG-1:0] stgvec_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  localparam logic [4:0] CAUSE_INSN_MISALIGN  = 5'd0;
  localparam logic [4:0] CAUSE_INSN_FAULT     = 5'd1;
  localparam logic [4:0] CAUSE_ILLEGAL_INSN   = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT     = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] CAUSE_LOAD_FAULT     = 5'd5;
  localparam logic [4:0] CAUSE_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] CAUSE_STORE_FAULT    = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_M        = 5'd11;

  // Mask holding the PC and every pipeline register up to and including 'upto'.
  function automatic stgvec_t stgMask(input int upto);
    stgvec_t m;
    for (int i = 0; i < NSTG; i++) begin
      m[i] = (i <= upto);
    end
    return m;
  endfunction

endpackage

// File: rtl/riscv_stall_wdog.sv
// Stall watchdog (saturating run-length counter with sticky flag) and a
// free-running count of stalled cycles.
module riscv_stall_wdog
  #(
    parameter int WDOG_MAX = 1024,
    parameter int CNT_W    = 32
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_any_i,
    output logic             wdog_o,
    output logic [CNT_W-1:0] stall_cnt_o
  );

  localparam int WW = (WDOG_MAX > 2) ? $clog2(WDOG_MAX) : 1;
  localparam logic [WW-1:0] WLIM = WW'(WDOG_MAX - 1);

  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             wdog_q, wdog_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on a stalled cycle that finds the run length already at its limit.
  always_comb begin
    wcnt_d = '0;
    wdog_d = wdog_q;
    cnt_d  = cnt_q;
    if (stall_any_i) begin
      wcnt_d = (wcnt_q == WLIM) ? wcnt_q : wcnt_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (wcnt_q == WLIM) begin
        wdog_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      wdog_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wdog_o      = wdog_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline hazard/sequencing controller: resolves stage stall requests,
// accepts EX branch redirects and sequences MEM-stage trap entry.
module riscv_pipe_ctrl
  import riscv_pipe_ctrl_pkg::*;
  #(
    parameter int XLEN     = 32,
    parameter int WDOG_MAX = 1024,
    parameter int CNT_W    = 32
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_if_i,
    input  logic             req_id_i,
    input  logic             req_ex_i,
    input  logic             req_mem_i,
    input  logic             br_taken_i,
    input  logic [XLEN-1:0]  br_target_i,
    input  logic             exc_valid_i,
    input  logic [XLEN-1:0]  exc_pc_i,
    input  logic [4:0]       exc_cause_i,
    input  logic [XLEN-1:0]  mtvec_i,
    output logic [NSTG-1:0]  stall_o,
    output logic [NSTG-1:0]  flush_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             trap_o,
    output logic [XLEN-1:0]  trap_epc_o,
    output logic [4:0]       trap_cause_o,
    output logic             wdog_o,
    output logic [CNT_W-1:0] stall_cnt_o
  );

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [4:0]      cause_q, cause_d;

  // An accepted branch clears stall[1:0] after resolution: any IF/ID stall
  // it overrides belongs to wrong-path instructions anyway.
  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    stall_o          = '0;
    flush_o          = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    trap_o           = 1'b0;
    case (state_q)
      ST_TRAP: begin
        redirect_valid_o  = 1'b1;
        redirect_pc_o     = {mtvec_i[XLEN-1:2], 2'b00};
        flush_o[STG_IFID] = 1'b1;
        trap_o            = 1'b1;
        state_d           = ST_RUN;
      end
      default: begin
        if (exc_valid_i && !req_mem_i) begin
          stall_o = stgMask(STG_PC);
          flush_o = ~stgMask(STG_PC);
          epc_d   = exc_pc_i;
          cause_d = exc_cause_i;
          state_d = ST_TRAP;
        end else begin
          if (req_mem_i) begin
            stall_o            = stgMask(STG_EXMEM);
            flush_o[STG_MEMWB] = 1'b1;
          end else if (req_ex_i) begin
            stall_o            = stgMask(STG_IDEX);
            flush_o[STG_EXMEM] = 1'b1;
          end else if (req_id_i) begin
            stall_o           = stgMask(STG_IFID);
            flush_o[STG_IDEX] = 1'b1;
          end else if (req_if_i) begin
            stall_o           = stgMask(STG_PC);
            flush_o[STG_IFID] = 1'b1;
          end
          if (br_taken_i && !req_mem_i && !req_ex_i) begin
            redirect_valid_o  = 1'b1;
            redirect_pc_o     = br_target_i;
            flush_o[STG_IFID] = 1'b1;
            flush_o[STG_IDEX] = 1'b1;
            stall_o[STG_PC]   = 1'b0;
            stall_o[STG_IFID] = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign trap_epc_o   = epc_q;
  assign trap_cause_o = cause_q;

  riscv_stall_wdog #(
    .WDOG_MAX (WDOG_MAX),
    .CNT_W    (CNT_W)
  ) u_wdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_any_i (|stall_o),
    .wdog_o      (wdog_o),
    .stall_cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed self-checking bench for riscv_pipe_ctrl (WDOG_MAX=4 so the
// watchdog can be reached in a few cycles).
module tb_riscv_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_if_i, req_id_i, req_ex_i, req_mem_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        exc_valid_i;
  logic [31:0] exc_pc_i;
  logic [4:0]  exc_cause_i;
  logic [31:0] mtvec_i;
  logic [4:0]  stall_o, flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        trap_o;
  logic [31:0] trap_epc_o;
  logic [4:0]  trap_cause_o;
  logic        wdog_o;
  logic [31:0] stall_cnt_o;

  integer checks = 0;
  integer errors = 0;

  riscv_pipe_ctrl #(
    .XLEN     (32),
    .WDOG_MAX (4),
    .CNT_W    (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_if_i         (req_if_i),
    .req_id_i         (req_id_i),
    .req_ex_i         (req_ex_i),
    .req_mem_i        (req_mem_i),
    .br_taken_i       (br_taken_i),
    .br_target_i      (br_target_i),
    .exc_valid_i      (exc_valid_i),
    .exc_pc_i         (exc_pc_i),
    .exc_cause_i      (exc_cause_i),
    .mtvec_i          (mtvec_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .trap_o           (trap_o),
    .trap_epc_o       (trap_epc_o),
    .trap_cause_o     (trap_cause_o),
    .wdog_o           (wdog_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic rIf, input logic rId, input logic rEx,
                               input logic rMem, input logic br, input logic [31:0] tgt,
                               input logic exc, input logic [31:0] epc, input logic [4:0] cause);
    req_if_i    = rIf;
    req_id_i    = rId;
    req_ex_i    = rEx;
    req_mem_i   = rMem;
    br_taken_i  = br;
    br_target_i = tgt;
    exc_valid_i = exc;
    exc_pc_i    = epc;
    exc_cause_i = cause;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkComb(input string tag, input logic [4:0] stl, input logic [4:0] fl,
                           input logic rv, input logic [31:0] rpc);
    checkOutput({tag, ".stall"}, {27'd0, stall_o}, {27'd0, stl});
    checkOutput({tag, ".flush"}, {27'd0, flush_o}, {27'd0, fl});
    checkOutput({tag, ".rvalid"}, {31'd0, redirect_valid_o}, {31'd0, rv});
    checkOutput({tag, ".rpc"}, redirect_pc_o, rpc);
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    mtvec_i = 32'h203;
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0);
    #2;
    $display("[TB] reset state");
    checkComb("reset", 5'b00000, 5'b00000, 1'b0, 32'h0);
    checkOutput("reset.trap", {31'd0, trap_o}, 32'd0);
    checkOutput("reset.epc", trap_epc_o, 32'h0);
    checkOutput("reset.cause", {27'd0, trap_cause_o}, 32'd0);
    checkOutput("reset.wdog", {31'd0, wdog_o}, 32'd0);
    checkOutput("reset.cnt", stall_cnt_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] load-use stall");
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0);
    #2;
    checkComb("loaduse", 5'b00011, 5'b00100, 1'b0, 32'h0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0);
    #2;
    checkComb("loaduse.after", 5'b00000, 5'b00000, 1'b0, 32'h0);
    checkOutput("loaduse.cnt", stall_cnt_o, 32'd1);
    stepClock();

    $display("[TB] MEM wait with pending branch");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 32'h100, 0, 32'h0, 5'd0);
      #2;
      checkComb("memwait", 5'b01111, 5'b10000, 1'b0, 32'h0);
      stepClock();
    end
    checkOutput("memwait.wdog3", {31'd0, wdog_o}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'h100, 0, 32'h0, 5'd0);
    #2;
    checkComb("memwait.branch", 5'b00000, 5'b00110, 1'b1, 32'h100);
    stepClock();
    checkOutput("memwait.cnt", stall_cnt_o, 32'd4);

    $display("[TB] branch overrides IF stall");
    applyStimulus(1, 0, 0, 0, 1, 32'h40, 0, 32'h0, 5'd0);
    #2;
    checkComb("brif", 5'b00000, 5'b00110, 1'b1, 32'h40);
    stepClock();
    checkOutput("brif.cnt", stall_cnt_o, 32'd4);

    $display("[TB] exception with simultaneous branch");
    applyStimulus(0, 0, 0, 0, 1, 32'h500, 1, 32'h88, 5'd2);
    #2;
    checkComb("exc.entry", 5'b00001, 5'b11110, 1'b0, 32'h0);
    checkOutput("exc.entry.trap", {31'd0, trap_o}, 32'd0);
    stepClock();
    applyStimulus(1, 1, 1, 1, 1, 32'h500, 0, 32'h0, 5'd0);
    #2;
    checkComb("exc.trap", 5'b00000, 5'b00010, 1'b1, 32'h200);
    checkOutput("exc.trap.pulse", {31'd0, trap_o}, 32'd1);
    checkOutput("exc.trap.epc", trap_epc_o, 32'h88);
    checkOutput("exc.trap.cause", {27'd0, trap_cause_o}, 32'd2);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0);
    #2;
    checkComb("exc.run", 5'b00000, 5'b00000, 1'b0, 32'h0);
    checkOutput("exc.run.trap", {31'd0, trap_o}, 32'd0);
    checkOutput("exc.run.cnt", stall_cnt_o, 32'd5);
    stepClock();

    $display("[TB] exception held off by MEM wait");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'hC4, 5'd5);
      #2;
      checkComb("excmem.wait", 5'b01111, 5'b10000, 1'b0, 32'h0);
      stepClock();
      checkOutput("excmem.notrap", {31'd0, trap_o}, 32'd0);
      checkOutput("excmem.epc", trap_epc_o, 32'h88);
    end
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'hC4, 5'd5);
    #2;
    checkComb("excmem.entry", 5'b00001, 5'b11110, 1'b0, 32'h0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0);
    #2;
    checkOutput("excmem.trap", {31'd0, trap_o}, 32'd1);
    checkOutput("excmem.trap.epc", trap_epc_o, 32'hC4);
    checkOutput("excmem.trap.cause", {27'd0, trap_cause_o}, 32'd5);
    checkOutput("excmem.wdog3", {31'd0, wdog_o}, 32'd0);
    stepClock();
    checkOutput("excmem.cnt", stall_cnt_o, 32'd8);

    $display("[TB] watchdog on held EX stall");
    applyStimulus(0, 0, 1, 0, 1, 32'h300, 0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #2;
      checkComb("wdog.ex", 5'b00111, 5'b01000, 1'b0, 32'h0);
      stepClock();
    end
    checkOutput("wdog.before", {31'd0, wdog_o}, 32'd0);
    stepClock();
    checkOutput("wdog.fired", {31'd0, wdog_o}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0);
    stepClock();
    checkOutput("wdog.sticky", {31'd0, wdog_o}, 32'd1);
    checkOutput("wdog.cnt", stall_cnt_o, 32'd12);

    $display("[TB] reset during TRAP");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h10, 5'd7);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0);
    #1;
    checkOutput("rst.pretrap", {31'd0, trap_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkComb("rst.async", 5'b00000, 5'b00000, 1'b0, 32'h0);
    checkOutput("rst.trap", {31'd0, trap_o}, 32'd0);
    checkOutput("rst.epc", trap_epc_o, 32'h0);
    checkOutput("rst.cause", {27'd0, trap_cause_o}, 32'd0);
    checkOutput("rst.wdog", {31'd0, wdog_o}, 32'd0);
    checkOutput("rst.cnt", stall_cnt_o, 32'd0);
    stepClock();
    rst_n = 1'b1;
    stepClock();
    checkOutput("rst.run.trap", {31'd0, trap_o}, 32'd0);
    checkOutput("rst.run.rvalid", {31'd0, redirect_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
